// File: rtl/uart_rx_seq.sv
// Oversampled UART receiver with a one-word output holding register, frame/parity/overrun flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (default: 8N1-style, no parity).
module uart_rx_seq #(
  parameter int OVERSAMPLE = 16,
  parameter int WIDTH      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             rxd,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_error,
  output logic             parity_error,
  output logic             overrun,
  output logic             busy
);

  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(WIDTH + 1);

  // The IDLE detection tick is phase 0 of the start bit, so the counter reaches
  // OVERSAMPLE/2-1 on the tick where its registered value is OVERSAMPLE/2-2.
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2 - 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               load;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd) begin
            state_d = START;
            phase_d = '0;
          end
        end
        START: begin
          if (phase_q == PH_MID) begin
            phase_d = '0;
            if (rxd) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_idx_d = '0;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        DATA: begin
          if (phase_q == PH_LAST) begin
            phase_d   = '0;
            shift_d   = WIDTH'({rxd, shift_q} >> 1);
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            par_d   = rxd;
            state_d = STOP;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            load    = 1'b1;
            state_d = rxd ? IDLE : BREAK;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        BREAK: begin
          if (rxd) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register: a load is dropped (and overrun raised) only when the
  // previous word is still pending and is not being taken on this edge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (load) begin
      if (valid_q && !ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = ~rxd;
`ifdef UART_RX_PARITY_EN
        perr_d  = ^{shift_q, par_q};
`endif
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_seq.sv
// Directed bench for uart_rx_seq: OVERSAMPLE=16, WIDTH=8, tick high every clock.
// Tick indices are relative to the first low sample of each frame.
module tb_uart_rx_seq;

  logic       clk = 1'b0;
  logic       reset, tick, rxd, ready;
  logic [7:0] data;
  logic       valid, frame_error, parity_error, overrun, busy;

  uart_rx_seq #(.OVERSAMPLE(16), .WIDTH(8)) dut (
    .clock(clk), .reset(reset), .tick(tick), .rxd(rxd), .ready(ready),
    .data(data), .valid(valid), .frame_error(frame_error),
    .parity_error(parity_error), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int STOP_T = 167;
`else
  localparam int STOP_T = 151;
`endif
  localparam int FR_T = STOP_T + 20;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] f_data;
  logic       f_stop;
  int         f_low_to;
  int         f_glitch;
`ifdef UART_RX_PARITY_EN
  logic       f_par;
`endif

  int         first_vld, vld_cnt, last_busy;
  logic [7:0] d_at;
  logic       fe_at, pe_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_frame(input logic [7:0] d, input logic stopb);
    f_data   = d;
    f_stop   = stopb;
    f_low_to = -1;
    f_glitch = 0;
`ifdef UART_RX_PARITY_EN
    f_par    = ^d;
`endif
  endtask

  function automatic logic line_at(input int t);
    int p;
    logic [7:0] sh;
    if (f_glitch > 0) return (t < f_glitch) ? 1'b0 : 1'b1;
    if (t < 16) return 1'b0;
    p = t - 16;
    if (p < 128) begin
      sh = f_data >> (p / 16);
      return sh[0];
    end
    p = p - 128;
`ifdef UART_RX_PARITY_EN
    if (p < 16) return f_par;
    p = p - 16;
`endif
    if (p < 16) return f_stop;
    return (t <= f_low_to) ? 1'b0 : 1'b1;
  endfunction

  task automatic run(input int n);
    first_vld = -1;
    vld_cnt   = 0;
    last_busy = -1;
    d_at      = '0;
    fe_at     = 1'b0;
    pe_at     = 1'b0;
    for (int t = 0; t < n; t++) begin
      rxd = line_at(t);
      cyc();
      if (valid === 1'b1) begin
        if (first_vld < 0) begin
          first_vld = t + 1;
          d_at      = data;
          fe_at     = frame_error;
          pe_at     = parity_error;
        end
        vld_cnt++;
      end
      if (busy === 1'b1) last_busy = t + 1;
    end
    rxd = 1'b1;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; rxd = 1'b1; ready = 1'b1;
    set_frame(8'h00, 1'b1);
    repeat (3) cyc();
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    chk("rst_perr", 32'(parity_error), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (4) cyc();

    // Clean frame 0xA5, consumer always ready
    ready = 1'b1;
    set_frame(8'hA5, 1'b1);
    run(FR_T);
    chk("a5_vld_tick", 32'(first_vld), 32'(STOP_T + 1));
    chk("a5_vld_len", 32'(vld_cnt), 32'd1);
    chk("a5_data", 32'(d_at), 32'hA5);
    chk("a5_ferr", 32'(fe_at), 32'h0);
    chk("a5_perr", 32'(pe_at), 32'h0);
    chk("a5_last_busy", 32'(last_busy), 32'(STOP_T));
    chk("a5_ovr", 32'(overrun), 32'h0);

    // False start: low for ticks 0-3 only
    f_glitch = 4;
    run(20);
    chk("fs_last_busy", 32'(last_busy), 32'd7);
    chk("fs_vld_cnt", 32'(vld_cnt), 32'd0);
    chk("fs_data_held", 32'(data), 32'hA5);

    // Low stop bit then line held low (break) to tick 300
    ready = 1'b0;
    set_frame(8'h3C, 1'b0);
    f_low_to = 300;
    run(320);
    chk("brk_vld_tick", 32'(first_vld), 32'(STOP_T + 1));
    chk("brk_data", 32'(d_at), 32'h3C);
    chk("brk_ferr", 32'(fe_at), 32'h1);
    chk("brk_last_busy", 32'(last_busy), 32'd301);
    chk("brk_valid_end", 32'(valid), 32'h1);
    chk("brk_busy_end", 32'(busy), 32'h0);
    chk("brk_ovr", 32'(overrun), 32'h0);
    ready = 1'b1;
    cyc();
    chk("brk_xfer_valid", 32'(valid), 32'h0);

`ifdef UART_RX_PARITY_EN
    // Parity frames 0x03: correct even parity (0), then wrong parity (1)
    ready = 1'b1;
    set_frame(8'h03, 1'b1);
    f_par = 1'b0;
    run(FR_T);
    chk("par0_vld_tick", 32'(first_vld), 32'd168);
    chk("par0_data", 32'(d_at), 32'h03);
    chk("par0_perr", 32'(pe_at), 32'h0);
    set_frame(8'h03, 1'b1);
    f_par = 1'b1;
    run(FR_T);
    chk("par1_perr", 32'(pe_at), 32'h1);
    chk("par1_ferr", 32'(fe_at), 32'h0);
`endif

    // Overrun: two frames with consumer stalled
    ready = 1'b0;
    set_frame(8'h11, 1'b1);
    run(FR_T);
    chk("ovr_first_data", 32'(data), 32'h11);
    chk("ovr_first_valid", 32'(valid), 32'h1);
    chk("ovr_first_flag", 32'(overrun), 32'h0);
    set_frame(8'h22, 1'b1);
    run(FR_T);
    chk("ovr_data_held", 32'(data), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    cyc();
    chk("ovr_xfer_valid", 32'(valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    cyc();
    chk("ovr_sticky2", 32'(overrun), 32'h1);

    // Reset in the middle of a frame at tick 50
    ready = 1'b0;
    set_frame(8'h96, 1'b1);
    run(50);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    rxd = line_at(50);
    cyc();
    chk("mr_data", 32'(data), 32'h0);
    chk("mr_valid", 32'(valid), 32'h0);
    chk("mr_ferr", 32'(frame_error), 32'h0);
    chk("mr_perr", 32'(parity_error), 32'h0);
    chk("mr_ovr", 32'(overrun), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    rxd = 1'b1;
    repeat (4) cyc();
    ready = 1'b1;
    set_frame(8'h5A, 1'b1);
    run(FR_T);
    chk("post_vld_tick", 32'(first_vld), 32'(STOP_T + 1));
    chk("post_data", 32'(d_at), 32'h5A);
    chk("post_ferr", 32'(fe_at), 32'h0);
    chk("post_ovr", 32'(overrun), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
